// File: rtl/reset_pkg.sv
// Shared types and constants for the reset sequencer and its soft-request handshake.
package reset_pkg;

  typedef enum logic [1:0] {
    ST_ASSERT,
    ST_RELEASE,
    ST_RUN
  } state_t;

  localparam logic CAUSE_HARD       = 1'b0;
  localparam logic CAUSE_SOFT       = 1'b1;
  localparam int   SOFT_COUNT_WIDTH = 8;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/reset_req_handshake.sv
// Four-phase soft-reset request/ack; emits a one-cycle accept pulse only while the sequencer is running.
module reset_req_handshake (
  input  logic clk,
  input  logic srst,
  input  logic req,
  input  logic run,
  output logic ack,
  output logic accept
);

  logic ack_reg;
  logic ack_next;

  // A new request is only taken once the previous handshake has fully closed.
  assign accept = run && req && !ack_reg;

  always_comb begin
    ack_next = ack_reg;
    if (accept) begin
      ack_next = 1'b1;
    end else if (ack_reg && !req) begin
      ack_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      ack_reg <= 1'b0;
    end else begin
      ack_reg <= ack_next;
    end
  end

  assign ack = ack_reg;

endmodule

// File: rtl/reset_sequencer.sv
// Stretches a hard or soft reset, then releases per-stage resets in order with a fixed gap.
module reset_sequencer
  import reset_pkg::*;
#(
  parameter int NUM_STAGES       = 3,
  parameter int STRETCH_CYCLES   = 16,
  parameter int STAGE_GAP_CYCLES = 4
) (
  input  logic                        _iClk,
  input  logic                        _iReset,
  input  logic                        _iSoftReq,
  output logic                        _oSoftAck,
  output logic [NUM_STAGES-1:0]       _oStageReset,
  output logic                        _oReady,
  output logic                        _oCauseSoft,
  output logic [SOFT_COUNT_WIDTH-1:0] _oSoftCount
);

  localparam int CNT_W = $clog2(max_int(STRETCH_CYCLES, STAGE_GAP_CYCLES) + 1);
  localparam int IDX_W = $clog2(NUM_STAGES + 1);
  localparam logic [CNT_W-1:0] STRETCH_LAST = CNT_W'(STRETCH_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(STAGE_GAP_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(NUM_STAGES - 1);

  if (NUM_STAGES < 1 || STRETCH_CYCLES < 1 || STAGE_GAP_CYCLES < 1) begin : g_param_check
    $error("reset_sequencer: NUM_STAGES, STRETCH_CYCLES and STAGE_GAP_CYCLES must all be >= 1");
  end

  state_t                      state_reg, state_next;
  logic [CNT_W-1:0]            count_reg, count_next;
  logic [IDX_W-1:0]            idx_reg, idx_next;
  logic                        ready_reg, ready_next;
  logic                        cause_reg, cause_next;
  logic [SOFT_COUNT_WIDTH-1:0] soft_count_reg, soft_count_next;
  logic [NUM_STAGES-1:0]       stage_reset_reg;
  logic                        release_fire;
  logic [IDX_W-1:0]            release_idx;
  logic                        accept;
  logic                        soft_ack;

  reset_req_handshake u_handshake (
    .clk    (_iClk),
    .srst   (_iReset),
    .req    (_iSoftReq),
    .run    (state_reg == ST_RUN),
    .ack    (soft_ack),
    .accept (accept)
  );

  always_comb begin
    state_next      = state_reg;
    count_next      = count_reg;
    idx_next        = idx_reg;
    ready_next      = 1'b0;
    cause_next      = cause_reg;
    soft_count_next = soft_count_reg;
    release_fire    = 1'b0;
    release_idx     = '0;
    case (state_reg)
      ST_ASSERT: begin
        if (count_reg == STRETCH_LAST) begin
          release_fire = 1'b1;
          release_idx  = '0;
          count_next   = '0;
          idx_next     = IDX_W'(1);
          state_next   = (NUM_STAGES == 1) ? ST_RUN : ST_RELEASE;
        end else begin
          count_next = count_reg + 1'b1;
        end
      end
      ST_RELEASE: begin
        if (count_reg == GAP_LAST) begin
          release_fire = 1'b1;
          release_idx  = idx_reg;
          count_next   = '0;
          idx_next     = idx_reg + 1'b1;
          if (idx_reg == LAST_IDX) begin
            state_next = ST_RUN;
          end
        end else begin
          count_next = count_reg + 1'b1;
        end
      end
      ST_RUN: begin
        ready_next = 1'b1;
        if (accept) begin
          ready_next = 1'b0;
          state_next = ST_ASSERT;
          count_next = '0;
          cause_next = CAUSE_SOFT;
          if (soft_count_reg != {SOFT_COUNT_WIDTH{1'b1}}) begin
            soft_count_next = soft_count_reg + 1'b1;
          end
        end
      end
      default: begin
        state_next = ST_ASSERT;
        count_next = '0;
      end
    endcase
  end

  always_ff @(posedge _iClk) begin
    if (_iReset) begin
      state_reg      <= ST_ASSERT;
      count_reg      <= '0;
      idx_reg        <= '0;
      ready_reg      <= 1'b0;
      cause_reg      <= CAUSE_HARD;
      soft_count_reg <= '0;
    end else begin
      state_reg      <= state_next;
      count_reg      <= count_next;
      idx_reg        <= idx_next;
      ready_reg      <= ready_next;
      cause_reg      <= cause_next;
      soft_count_reg <= soft_count_next;
    end
  end

  // Each bit only clears on its own release slot; any reset source sets all bits together.
  for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_stage
    always_ff @(posedge _iClk) begin
      if (_iReset || accept) begin
        stage_reset_reg[gi] <= 1'b1;
      end else if (release_fire && (release_idx == IDX_W'(gi))) begin
        stage_reset_reg[gi] <= 1'b0;
      end
    end
  end

  assign _oSoftAck    = soft_ack;
  assign _oStageReset = stage_reset_reg;
  assign _oReady      = ready_reg;
  assign _oCauseSoft  = cause_reg;
  assign _oSoftCount  = soft_count_reg;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: default parameters plus a minimal 1/1/1 instance.
module tb_reset_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req = 1'b0;
  logic       ack;
  logic [2:0] stage;
  logic       ready;
  logic       cause;
  logic [7:0] count;

  logic       rst_m = 1'b1;
  logic       req_m = 1'b0;
  logic       ack_m;
  logic [0:0] stage_m;
  logic       ready_m;
  logic       cause_m;
  logic [7:0] count_m;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  reset_sequencer dut (
    ._iClk        (clk),
    ._iReset      (rst),
    ._iSoftReq    (req),
    ._oSoftAck    (ack),
    ._oStageReset (stage),
    ._oReady      (ready),
    ._oCauseSoft  (cause),
    ._oSoftCount  (count)
  );

  reset_sequencer #(
    .NUM_STAGES       (1),
    .STRETCH_CYCLES   (1),
    .STAGE_GAP_CYCLES (1)
  ) dut_min (
    ._iClk        (clk),
    ._iReset      (rst_m),
    ._iSoftReq    (req_m),
    ._oSoftAck    (ack_m),
    ._oStageReset (stage_m),
    ._oReady      (ready_m),
    ._oCauseSoft  (cause_m),
    ._oSoftCount  (count_m)
  );

  // Advance one edge and settle, so inputs change and outputs are read away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected stage vector k edges after the first release-counting edge; base is the stage-0 release offset.
  function automatic logic [2:0] exp_stage(input int k, input int base);
    logic [2:0] v;
    for (int i = 0; i < 3; i++) v[i] = (k < base + 4 * i);
    return v;
  endfunction

  task automatic hard_reset_to_run();
    rst = 1'b1;
    req = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();
    repeat (24) step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = 1'b0;
    repeat (5) step();
    checks++; if (stage !== 3'b111) begin failures++; $display("FAIL reset_stage got=%b exp=111", stage); end
    checks++; if (ready !== 1'b0)   begin failures++; $display("FAIL reset_ready got=%b exp=0", ready); end
    checks++; if (ack !== 1'b0)     begin failures++; $display("FAIL reset_ack got=%b exp=0", ack); end
    checks++; if (cause !== 1'b0)   begin failures++; $display("FAIL reset_cause got=%b exp=0", cause); end
    checks++; if (count !== 8'd0)   begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
    $display("test_reset: stage=%b ready=%b ack=%b cause=%b count=%0d", stage, ready, ack, cause, count);
  endtask

  task automatic test_hard_release();
    rst = 1'b0;
    for (int k = 0; k <= 27; k++) begin
      step();
      checks++; if (stage !== exp_stage(k, 15)) begin failures++; $display("FAIL hard_stage k=%0d got=%b exp=%b", k, stage, exp_stage(k, 15)); end
      checks++; if (ready !== (k >= 24))        begin failures++; $display("FAIL hard_ready k=%0d got=%b exp=%b", k, ready, k >= 24); end
    end
    checks++; if (cause !== 1'b0) begin failures++; $display("FAIL hard_cause got=%b exp=0", cause); end
    checks++; if (count !== 8'd0) begin failures++; $display("FAIL hard_count got=%0d exp=0", count); end
    $display("test_hard_release: stage=%b ready=%b", stage, ready);
  endtask

  task automatic test_soft_reset();
    req = 1'b1;
    step();
    checks++; if (stage !== 3'b111) begin failures++; $display("FAIL soft_stage got=%b exp=111", stage); end
    checks++; if (ready !== 1'b0)   begin failures++; $display("FAIL soft_ready got=%b exp=0", ready); end
    checks++; if (ack !== 1'b1)     begin failures++; $display("FAIL soft_ack got=%b exp=1", ack); end
    checks++; if (cause !== 1'b1)   begin failures++; $display("FAIL soft_cause got=%b exp=1", cause); end
    checks++; if (count !== 8'd1)   begin failures++; $display("FAIL soft_count got=%0d exp=1", count); end
    for (int j = 1; j <= 26; j++) begin
      if (j == 3) req = 1'b0;
      step();
      checks++; if (ack !== (j < 3))            begin failures++; $display("FAIL soft_ack_seq j=%0d got=%b exp=%b", j, ack, j < 3); end
      checks++; if (stage !== exp_stage(j, 16)) begin failures++; $display("FAIL soft_stage_seq j=%0d got=%b exp=%b", j, stage, exp_stage(j, 16)); end
      checks++; if (ready !== (j >= 25))        begin failures++; $display("FAIL soft_ready_seq j=%0d got=%b exp=%b", j, ready, j >= 25); end
    end
    $display("test_soft_reset: count=%0d cause=%b ready=%b", count, cause, ready);
  endtask

  task automatic test_soft_hold();
    hard_reset_to_run();
    req = 1'b1;
    step();
    checks++; if (count !== 8'd1) begin failures++; $display("FAIL hold_first_count got=%0d exp=1", count); end
    for (int j = 1; j <= 28; j++) begin
      step();
      checks++; if (ack !== 1'b1)        begin failures++; $display("FAIL hold_ack j=%0d got=%b exp=1", j, ack); end
      checks++; if (count !== 8'd1)      begin failures++; $display("FAIL hold_count j=%0d got=%0d exp=1", j, count); end
      checks++; if (ready !== (j >= 25)) begin failures++; $display("FAIL hold_ready j=%0d got=%b exp=%b", j, ready, j >= 25); end
    end
    req = 1'b0;
    step();
    checks++; if (ack !== 1'b0) begin failures++; $display("FAIL hold_drop_ack got=%b exp=0", ack); end
    req = 1'b1;
    step();
    checks++; if (ack !== 1'b1)     begin failures++; $display("FAIL hold_reraise_ack got=%b exp=1", ack); end
    checks++; if (count !== 8'd2)   begin failures++; $display("FAIL hold_reraise_count got=%0d exp=2", count); end
    checks++; if (stage !== 3'b111) begin failures++; $display("FAIL hold_reraise_stage got=%b exp=111", stage); end
    req = 1'b0;
    step();
    $display("test_soft_hold: count=%0d ack=%b", count, ack);
  endtask

  task automatic test_req_during_assert();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    req = 1'b1;
    step();
    for (int k = 1; k <= 23; k++) begin
      step();
      checks++; if (ack !== 1'b0)               begin failures++; $display("FAIL early_ack k=%0d got=%b exp=0", k, ack); end
      checks++; if (count !== 8'd0)             begin failures++; $display("FAIL early_count k=%0d got=%0d exp=0", k, count); end
      checks++; if (stage !== exp_stage(k, 15)) begin failures++; $display("FAIL early_stage k=%0d got=%b exp=%b", k, stage, exp_stage(k, 15)); end
    end
    step();
    checks++; if (ack !== 1'b1)     begin failures++; $display("FAIL early_accept_ack got=%b exp=1", ack); end
    checks++; if (count !== 8'd1)   begin failures++; $display("FAIL early_accept_count got=%0d exp=1", count); end
    checks++; if (stage !== 3'b111) begin failures++; $display("FAIL early_accept_stage got=%b exp=111", stage); end
    checks++; if (cause !== 1'b1)   begin failures++; $display("FAIL early_accept_cause got=%b exp=1", cause); end
    req = 1'b0;
    step();
    $display("test_req_during_assert: count=%0d ack=%b", count, ack);
  endtask

  task automatic test_hard_mid_sequence();
    hard_reset_to_run();
    req = 1'b1;
    step();
    repeat (20) step();
    checks++; if (stage !== 3'b100) begin failures++; $display("FAIL mid_pre_stage got=%b exp=100", stage); end
    checks++; if (ack !== 1'b1)     begin failures++; $display("FAIL mid_pre_ack got=%b exp=1", ack); end
    rst = 1'b1;
    req = 1'b0;
    step();
    checks++; if (stage !== 3'b111) begin failures++; $display("FAIL mid_stage got=%b exp=111", stage); end
    checks++; if (ready !== 1'b0)   begin failures++; $display("FAIL mid_ready got=%b exp=0", ready); end
    checks++; if (ack !== 1'b0)     begin failures++; $display("FAIL mid_ack got=%b exp=0", ack); end
    checks++; if (cause !== 1'b0)   begin failures++; $display("FAIL mid_cause got=%b exp=0", cause); end
    checks++; if (count !== 8'd0)   begin failures++; $display("FAIL mid_count got=%0d exp=0", count); end
    rst = 1'b0;
    for (int k = 0; k <= 24; k++) begin
      step();
      checks++; if (stage !== exp_stage(k, 15)) begin failures++; $display("FAIL mid_restart_stage k=%0d got=%b exp=%b", k, stage, exp_stage(k, 15)); end
      checks++; if (ready !== (k >= 24))        begin failures++; $display("FAIL mid_restart_ready k=%0d got=%b exp=%b", k, ready, k >= 24); end
    end
    $display("test_hard_mid_sequence: stage=%b ready=%b", stage, ready);
  endtask

  task automatic test_saturation();
    int exp_count;
    hard_reset_to_run();
    for (int n = 1; n <= 260; n++) begin
      req = 1'b1;
      step();
      exp_count = (n > 255) ? 255 : n;
      checks++; if (count !== 8'(exp_count)) begin failures++; $display("FAIL sat_count n=%0d got=%0d exp=%0d", n, count, exp_count); end
      req = 1'b0;
      step();
      repeat (23) step();
    end
    $display("test_saturation: count=%0d", count);
  endtask

  task automatic test_min_params();
    rst_m = 1'b1;
    req_m = 1'b0;
    step();
    checks++; if (stage_m !== 1'b1) begin failures++; $display("FAIL min_reset_stage got=%b exp=1", stage_m); end
    checks++; if (ready_m !== 1'b0) begin failures++; $display("FAIL min_reset_ready got=%b exp=0", ready_m); end
    rst_m = 1'b0;
    step();
    checks++; if (stage_m !== 1'b0) begin failures++; $display("FAIL min_t1_stage got=%b exp=0", stage_m); end
    checks++; if (ready_m !== 1'b0) begin failures++; $display("FAIL min_t1_ready got=%b exp=0", ready_m); end
    step();
    checks++; if (ready_m !== 1'b1) begin failures++; $display("FAIL min_t1p1_ready got=%b exp=1", ready_m); end
    req_m = 1'b1;
    step();
    checks++; if (stage_m !== 1'b1) begin failures++; $display("FAIL min_soft_stage got=%b exp=1", stage_m); end
    checks++; if (ack_m !== 1'b1)   begin failures++; $display("FAIL min_soft_ack got=%b exp=1", ack_m); end
    checks++; if (count_m !== 8'd1) begin failures++; $display("FAIL min_soft_count got=%0d exp=1", count_m); end
    req_m = 1'b0;
    step();
    checks++; if (stage_m !== 1'b0) begin failures++; $display("FAIL min_soft_release got=%b exp=0", stage_m); end
    checks++; if (ready_m !== 1'b0) begin failures++; $display("FAIL min_soft_ready_early got=%b exp=0", ready_m); end
    checks++; if (ack_m !== 1'b0)   begin failures++; $display("FAIL min_soft_ack_drop got=%b exp=0", ack_m); end
    step();
    checks++; if (ready_m !== 1'b1) begin failures++; $display("FAIL min_soft_ready got=%b exp=1", ready_m); end
    $display("test_min_params: stage=%b ready=%b count=%0d", stage_m, ready_m, count_m);
  endtask

  initial begin
    test_reset();
    test_hard_release();
    test_soft_reset();
    test_soft_hold();
    test_req_during_assert();
    test_hard_mid_sequence();
    test_saturation();
    test_min_params();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
